// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO mul/div controller: op codes, FSM states,
// the divide-by-zero quotient, and a conditional two's-complement helper.
package muldiv_ctrl_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL     = 2'd1,
    S_DIV_RUN = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  function automatic logic [31:0] neg_if(input logic en, input logic [31:0] v);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div.sv
// Iterative restoring radix-2 divider on unsigned magnitudes; one quotient
// bit per cycle after load, with last raised once all bits are produced.
module div_radix2_iter #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        last
);

  localparam logic [5:0] LAST_CNT = 6'(DIV_CYCLES);

  logic [32:0] rem_r;
  logic [31:0] quot_r;
  logic [31:0] div_r;
  logic [5:0]  cnt_r;
  logic [33:0] shifted_s;
  logic [32:0] diff_s;
  logic        ge_s;

  assign shifted_s = {rem_r, quot_r[31]};
  assign ge_s      = (shifted_s >= {2'b00, div_r});
  assign diff_s    = shifted_s[32:0] - {1'b0, div_r};

  // Load operands, then shift-subtract one bit per cycle until the count expires
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r  <= 33'd0;
      quot_r <= 32'd0;
      div_r  <= 32'd0;
      cnt_r  <= 6'd0;
    end else if (load) begin
      rem_r  <= 33'd0;
      quot_r <= dividend;
      div_r  <= divisor;
      cnt_r  <= 6'd0;
    end else if (cnt_r != LAST_CNT) begin
      rem_r  <= ge_s ? diff_s : shifted_s[32:0];
      quot_r <= {quot_r[30:0], ge_s};
      cnt_r  <= cnt_r + 6'd1;
    end else begin
      rem_r  <= rem_r;
      quot_r <= quot_r;
      div_r  <= div_r;
      cnt_r  <= cnt_r;
    end
  end

  assign quot = quot_r;
  assign rem  = rem_r[31:0];
  assign last = (cnt_r == LAST_CNT);

endmodule

// File: rtl/muldiv_ctrl.sv
// Execute-stage HI/LO controller: single-cycle multiply, iterative divide,
// pipeline stall while busy, one-cycle done pulse with HI/LO write enables.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [1:0]  hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy
);

  state_t      state_r;
  logic [1:0]  op_r;
  logic [31:0] a_r, b_r, hi_r, lo_r;
  logic [1:0]  we_r;
  logic        done_r, busy_r;

  logic        accept_s;
  logic        div_signed_s;
  logic [31:0] dividend_s, divisor_s, quot_s, rem_s, q_fix_s, r_fix_s;
  logic        last_s, neg_a_s, neg_b_s, mul_signed_s;
  logic [63:0] ma_s, mb_s, prod_s;

  assign accept_s     = (state_r == S_IDLE) && start && !flush;
  assign div_signed_s = (op == MD_DIV);
  assign dividend_s   = neg_if(div_signed_s & src_a[31], src_a);
  assign divisor_s    = neg_if(div_signed_s & src_b[31], src_b);

  div_radix2_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .dividend (dividend_s),
    .divisor  (divisor_s),
    .quot     (quot_s),
    .rem      (rem_s),
    .last     (last_s)
  );

  // Sign-extending to 64 bits makes the truncated product correct for MULT and MULTU alike
  assign mul_signed_s = (op_r == MD_MULT);
  assign ma_s   = {{32{mul_signed_s & a_r[31]}}, a_r};
  assign mb_s   = {{32{mul_signed_s & b_r[31]}}, b_r};
  assign prod_s = ma_s * mb_s;

  assign neg_a_s = (op_r == MD_DIV) & a_r[31];
  assign neg_b_s = (op_r == MD_DIV) & b_r[31];
  assign q_fix_s = neg_if(neg_a_s ^ neg_b_s, quot_s);
  assign r_fix_s = neg_if(neg_a_s, rem_s);

  // Controller FSM with registered result, done, write-enable and busy outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      op_r    <= 2'b00;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      done_r  <= 1'b0;
      we_r    <= 2'b00;
      busy_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      we_r   <= 2'b00;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r    <= op;
            a_r     <= src_a;
            b_r     <= src_b;
            busy_r  <= 1'b1;
            state_r <= (op[1] && (src_b != 32'd0)) ? S_DIV_RUN : S_MUL;
          end else begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_MUL: begin
          if (flush) begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            // Divides only land here when the divisor was zero
            hi_r    <= op_r[1] ? a_r : prod_s[63:32];
            lo_r    <= op_r[1] ? DIV_ZERO_QUOT : prod_s[31:0];
            done_r  <= 1'b1;
            we_r    <= 2'b11;
            busy_r  <= 1'b1;
            state_r <= S_DONE;
          end
        end
        S_DIV_RUN: begin
          if (flush) begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else if (last_s) begin
            hi_r    <= r_fix_s;
            lo_r    <= q_fix_s;
            done_r  <= 1'b1;
            we_r    <= 2'b11;
            busy_r  <= 1'b1;
            state_r <= S_DONE;
          end else begin
            busy_r  <= 1'b1;
            state_r <= S_DIV_RUN;
          end
        end
        S_DONE: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign stall   = accept_s | (state_r == S_MUL) | (state_r == S_DIV_RUN);
  assign done    = done_r;
  assign hilo_we = we_r;
  assign hi_out  = hi_r;
  assign lo_out  = lo_r;
  assign busy    = busy_r;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Execute-stage controller for the HI/LO arithmetic unit. It accepts MULT, MULTU, DIV and DIVU issued from the decoder's mul/div path.
- Sequences a single-cycle multiplier and an iterative radix-2 divider, and holds the pipeline with a stall while the operation is in progress.
- Presents the 64-bit {HI, LO} result with HI/LO write enables for one cycle, to be captured by the HILO register file.
- Supports flush, which aborts an in-flight operation.

Parameters:
- DIV_CYCLES, 32, number of divider iteration cycles. Equals the operand width; only 32 is supported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  execute-stage instruction is mul/div (isMulOrDiv & valid). Held stable by the pipeline while stall=1.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled only when an operation is accepted.
- src_a  in  32  rs operand: dividend or multiplicand. Sampled only when an operation is accepted.
- src_b  in  32  rt operand: divisor or multiplier. Sampled only when an operation is accepted.
- flush  in  1  exception/flush of the execute stage; aborts the current operation.
- stall  out  1  freeze fetch through execute.
- done  out  1  one-cycle pulse; hi_out/lo_out valid in this cycle.
- hilo_we  out  2  {HI write, LO write}; 2'b11 only while done=1, otherwise 2'b00.
- hi_out  out  32  HI result: product[63:32] or remainder.
- lo_out  out  32  LO result: product[31:0] or quotient.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - done=0, hilo_we=0, busy=0, stall=0 (with start=0), hi_out=0, lo_out=0.
  - Divider registers are cleared.
  - rst overrides start and flush.
- States: IDLE, MUL, DIV_RUN, DONE.
- IDLE:
  - Accept when start=1 and flush=0: latch op, src_a and src_b.
  - op[1]=0 goes to MUL. op[1]=1 with src_b!=0 goes to DIV_RUN with counter=0. op[1]=1 with src_b==0 goes to MUL (divide-by-zero fast path, see below).
- MUL:
  - Computes the 64-bit product, signed 33x33 for MULT and zero-extended for MULTU, registered into hi_out/lo_out.
  - Divide-by-zero: hi_out=src_a, lo_out=32'hFFFF_FFFF.
  - Next state is DONE.
- DIV_RUN:
  - Restoring divide on |src_a| and |src_b|; magnitudes are taken only for DIV, DIVU uses raw values.
  - One quotient bit per cycle; counter increments each cycle.
  - After DIV_CYCLES cycles go to DONE. Sign correction is applied on the DONE transition:
    - quotient is negated if sign(a) xor sign(b);
    - remainder takes the sign of the dividend.
  - 0x8000_0000 / 0xFFFF_FFFF (DIV) gives quotient 0x8000_0000, remainder 0 (32-bit wrap, no trap).
- DONE:
  - done=1, hilo_we=2'b11, stall=0. Next state is IDLE.
  - start is ignored in DONE: it is the same instruction, which advances at the end of this cycle.
- stall is combinational: stall = (state==IDLE & start & ~flush) | state==MUL | state==DIV_RUN.
- Latency from the accept cycle T:
  - MULT/MULTU and divide-by-zero: done at T+2, stall high for T and T+1.
  - DIV/DIVU: done at T+DIV_CYCLES+2 = T+34, stall high for 34 cycles.
- Back-to-back operations: a new start in the cycle after DONE (in IDLE) is accepted normally. There is no bubble requirement beyond the DONE cycle.
- flush:
  - Any cycle with flush=1 and not DONE forces state=IDLE next cycle, with no done and hilo_we=0. hi_out/lo_out keep their previous values.
  - flush in IDLE blocks acceptance. flush in DONE does not cancel the write.
- hi_out/lo_out hold their last result until the next done; they are only updated on transitions into DONE.
- Operands latched at accept are immune to later src_a/src_b changes.

Decomposition:
- Shared include define_muldiv.vh holds:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU;
  - state encodings S_IDLE/S_MUL/S_DIV_RUN/S_DONE (2 bits);
  - the 32'hFFFF_FFFF divide-by-zero quotient constant.
- One sub-module, div_radix2_iter:
  - holds the restoring-divide registers (remainder 33b, quotient 32b, divisor 32b, counter 6b);
  - inputs load, dividend, divisor; outputs quot, rem, last;
  - muldiv_ctrl owns the FSM, sign handling and the multiplier.

Test Plan:
- MULT src_a=0xFFFF_FFFE (-2), src_b=3 -> done at T+2, hi=0xFFFF_FFFF, lo=0xFFFF_FFFA, hilo_we=11, stall high exactly 2 cycles.
- MULTU src_a=0xFFFF_FFFF, src_b=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001 at T+2.
- DIV src_a=-7 (0xFFFF_FFF9), src_b=2 -> done at T+34, lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- DIVU src_a=0x1234, src_b=0 -> done at T+2, hi=0x1234, lo=0xFFFF_FFFF. DIV 0x8000_0000/-1 -> lo=0x8000_0000, hi=0.
- DIV started, flush asserted at T+10 -> state IDLE at T+11, no done pulse, stall low, hi/lo unchanged. Repeat with rst=1 mid-DIV -> all outputs 0 next cycle.
- Back-to-back: MULT 2*3 immediately followed by DIVU 9/4 (start held high through DONE) -> done at T+2 (lo=6), DIVU accepted at T+3 (no double issue in DONE), done at T+37 with lo=2, hi=1.
